grostl_sub_bytes_sched: RTL and testbench

- Shares one 64-bit SubBytes unit (8 S-box LUTs) between the Grøstl P and Q permutation engines of the dp64 datapath.
- Arbitrates between the two requesters round-robin.
- Streams the granted 512-bit state through the unit one 64-bit column per cycle.
- Returns the substituted state with a done pulse.

---
 rtl/grostl_sub_bytes_sched.sv | 112 +++++++++++
 tb/tb_grostl_sub_bytes_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/grostl_sub_bytes_sched.sv
// Shares one 64-bit SubBytes unit between the Groestl P and Q permutation
// engines. Round-robin arbitration picks a requester, its state is captured and
// streamed through the unit one column per cycle, then a done pulse is issued.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   p_req/q_req          engine requests, held until the matching gnt
//   p_state/q_state      engine states, sampled in the grant cycle
//   p_gnt/q_gnt          one-cycle grant pulses (combinational in IDLE)
//   p_done/q_done        one-cycle done pulses for the owning engine
//   res_state            substituted state buffer (valid at done)
//   sb_din/sb_dout       column to / result from the shared SubBytes unit
//   busy                 high while a pass is running or completing
//   owner                0 = P, 1 = Q; current or last granted requester
module grostl_sub_bytes_sched #(
  parameter int unsigned NCOLS = 8,
  parameter int unsigned CW    = $clog2(NCOLS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       p_req,
  input  logic [0:NCOLS-1][0:7][7:0] p_state,
  output logic                       p_gnt,
  output logic                       p_done,
  input  logic                       q_req,
  input  logic [0:NCOLS-1][0:7][7:0] q_state,
  output logic                       q_gnt,
  output logic                       q_done,
  output logic [0:NCOLS-1][0:7][7:0] res_state,
  output logic [0:7][7:0]            sb_din,
  input  logic [0:7][7:0]            sb_dout,
  output logic                       busy,
  output logic                       owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_nxt;
  logic [CW-1:0]              col;
  logic [0:NCOLS-1][0:7][7:0] buffer;
  logic                       last_col;

  assign last_col  = (col == CW'(NCOLS - 1));
  assign sb_din    = buffer[col];
  assign res_state = buffer;

  // Next state, grant arbitration and done decode
  always_comb begin
    state_nxt = state;
    p_gnt     = 1'b0;
    q_gnt     = 1'b0;
    p_done    = 1'b0;
    q_done    = 1'b0;
    unique case (state)
      IDLE: begin
        // On contention the requester that did not own the last pass wins
        if (p_req && (!q_req || owner)) begin
          p_gnt = 1'b1;
        end else if (q_req) begin
          q_gnt = 1'b1;
        end
        if (p_req || q_req) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_col) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        p_done    = ~owner;
        q_done    = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Capture granted state, then substitute one column per cycle in place
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer <= '0;
      col    <= '0;
      owner  <= 1'b1;
    end else if (p_gnt || q_gnt) begin
      buffer <= q_gnt ? q_state : p_state;
      owner  <= q_gnt;
      col    <= '0;
    end else if (state == RUN) begin
      buffer[col] <= sb_dout;
      col         <= last_col ? '0 : col + CW'(1);
    end
  end

endmodule

// File: tb/tb_grostl_sub_bytes_sched.sv
// Bench for grostl_sub_bytes_sched: models the shared SubBytes unit with the
// AES S-box, runs a table of known-answer passes, and a scoreboard monitor
// checks every column streamed and every done pulse against a reference.
module tb_grostl_sub_bytes_sched;

  localparam int unsigned NCOLS = 8;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef logic [0:NCOLS-1][0:7][7:0] st_t;
  typedef struct { logic who; int at; st_t exp; } sb_t;
  typedef struct { logic use_q; st_t st; st_t exp; } vec_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           p_req = 1'b0;
  logic           q_req = 1'b0;
  st_t            p_state = '0;
  st_t            q_state = '0;
  st_t            res_state;
  logic           p_gnt, p_done, q_gnt, q_done, busy, owner;
  logic [0:7][7:0] sb_din, sb_dout;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   run_idx = NCOLS;
  sb_t  sbq[$];
  sb_t  mon_e;
  st_t  cur;
  vec_t vecs[5];

  grostl_sub_bytes_sched #(.NCOLS(NCOLS)) dut (
    .clk(clk), .reset_n(reset_n),
    .p_req(p_req), .p_state(p_state), .p_gnt(p_gnt), .p_done(p_done),
    .q_req(q_req), .q_state(q_state), .q_gnt(q_gnt), .q_done(q_done),
    .res_state(res_state), .sb_din(sb_din), .sb_dout(sb_dout),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational SubBytes unit
  always_comb begin
    for (int i = 0; i < 8; i++) sb_dout[3'(i)] = SBOX[sb_din[3'(i)]];
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic st_t sub_state(input st_t s);
    st_t r;
    for (int j = 0; j < NCOLS; j++)
      for (int b = 0; b < 8; b++) r[3'(j)][3'(b)] = SBOX[s[3'(j)][3'(b)]];
    return r;
  endfunction

  function automatic st_t rand_state();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic wait_pulse(input bit want_done, input int max, output logic who, output int at);
    bit found = 1'b0;
    who = 1'b0;
    at  = -1;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (want_done ? (p_done | q_done) : (p_gnt | q_gnt)) begin
        found = 1'b1;
        who   = want_done ? q_done : q_gnt;
        at    = cyc;
      end
    end
    check(want_done ? "wait_done" : "wait_gnt", 512'(found), 512'(1'b1));
  endtask

  // Scoreboard monitor: push on grant, check columns in RUN, pop on done
  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete();
      run_idx = NCOLS;
    end else begin
      if (run_idx < int'(NCOLS)) begin
        check("sb_din_col", 512'(sb_din), 512'(cur[3'(run_idx)]));
        check("busy_run", 512'(busy), 512'(1'b1));
        run_idx++;
      end
      if (p_done || q_done) begin
        check("done_onehot", 512'(p_done & q_done), 512'(1'b0));
        check("done_gnt_overlap", 512'(p_gnt | q_gnt), 512'(1'b0));
        check("done_expected", 512'(sbq.size() != 0), 512'(1'b1));
        if (sbq.size() != 0) begin
          mon_e = sbq.pop_front();
          check("done_who", 512'(q_done), 512'(mon_e.who));
          check("done_cycle", 512'(cyc), 512'(mon_e.at));
          check("done_res_state", res_state, mon_e.exp);
          check("done_owner", 512'(owner), 512'(mon_e.who));
        end
      end
      if (p_gnt || q_gnt) begin
        check("gnt_onehot", 512'(p_gnt & q_gnt), 512'(1'b0));
        cur = q_gnt ? q_state : p_state;
        sbq.push_back('{who: q_gnt, at: cyc + int'(NCOLS) + 1, exp: sub_state(cur)});
        run_idx = 0;
      end
    end
  end

  initial begin
    logic       who;
    int         tg, td, d1, d2, g2, g3, cnt;
    logic [7:0] sj [8];

    sj = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};
    vecs[0] = '{use_q: 1'b0, st: '0,            exp: {64{8'h63}}};
    vecs[1] = '{use_q: 1'b1, st: {64{8'h53}},   exp: {64{8'hed}}};
    vecs[2] = '{use_q: 1'b1, st: '0,            exp: '0};
    for (int j = 0; j < NCOLS; j++) begin
      vecs[2].st[3'(j)]  = {8{8'(j)}};
      vecs[2].exp[3'(j)] = {8{sj[3'(j)]}};
    end
    vecs[3] = '{use_q: 1'b0, st: {64{8'hff}},   exp: {64{8'h16}}};
    vecs[4] = '{use_q: 1'b0, st: {64{8'h10}},   exp: {64{8'hca}}};

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_busy", 512'(busy), 512'(1'b0));
    check("rst_owner", 512'(owner), 512'(1'b1));
    check("rst_gnt", 512'(p_gnt | q_gnt), 512'(1'b0));
    check("rst_done", 512'(p_done | q_done), 512'(1'b0));
    check("rst_res_state", res_state, 512'(0));
    check("rst_sb_din", 512'(sb_din), 512'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 512'(busy), 512'(1'b0));
    check("idle_no_gnt", 512'(p_gnt | q_gnt), 512'(1'b0));

    // Known-answer passes
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      if (vecs[v].use_q) begin q_state = vecs[v].st; q_req = 1'b1; end
      else begin p_state = vecs[v].st; p_req = 1'b1; end
      wait_pulse(1'b0, 20, who, tg);
      check("vec_gnt_who", 512'(who), 512'(vecs[v].use_q));
      @(posedge clk); #1 p_req = 1'b0; q_req = 1'b0;
      wait_pulse(1'b1, 20, who, td);
      check("vec_latency", 512'(td - tg), 512'(NCOLS + 1));
      check("vec_done_who", 512'(who), 512'(vecs[v].use_q));
      check("vec_res_state", res_state, vecs[v].exp);
      check("vec_owner", 512'(owner), 512'(vecs[v].use_q));
    end
    repeat (3) @(negedge clk);
    check("res_retained", res_state, vecs[3].exp);
    check("idle_busy_after", 512'(busy), 512'(1'b0));

    // Random passes alternating requesters
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (k % 2 == 1) begin q_state = rand_state(); q_req = 1'b1; end
      else begin p_state = rand_state(); p_req = 1'b1; end
      wait_pulse(1'b0, 20, who, tg);
      @(posedge clk); #1 p_req = 1'b0; q_req = 1'b0;
      wait_pulse(1'b1, 20, who, td);
    end

    // Contention from reset release: P, Q, P
    @(posedge clk); #1 reset_n = 1'b0;
    p_state = rand_state(); q_state = rand_state(); p_req = 1'b1; q_req = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    wait_pulse(1'b0, 5, who, tg);
    check("cont_first_p", 512'(who), 512'(1'b0));
    wait_pulse(1'b1, 20, who, d1);
    wait_pulse(1'b0, 20, who, g2);
    check("cont_second_q", 512'(who), 512'(1'b1));
    check("cont_q_gnt_after_done", 512'(g2), 512'(d1 + 1));
    wait_pulse(1'b1, 20, who, d2);
    check("cont_done_spacing", 512'(d2 - d1), 512'(NCOLS + 2));
    wait_pulse(1'b0, 20, who, g3);
    check("cont_third_p", 512'(who), 512'(1'b0));
    check("cont_third_gnt_cycle", 512'(g3), 512'(d2 + 1));
    @(posedge clk); #1 p_req = 1'b0; q_req = 1'b0;
    wait_pulse(1'b1, 20, who, td);

    // Q request raised in the DONE cycle of a P pass
    @(posedge clk); #1 p_state = rand_state(); p_req = 1'b1;
    wait_pulse(1'b0, 20, who, tg);
    @(posedge clk); #1 p_req = 1'b0;
    repeat (NCOLS) @(posedge clk);
    #1 q_state = rand_state(); q_req = 1'b1;
    @(negedge clk);
    check("dc_p_done", 512'(p_done), 512'(1'b1));
    check("dc_no_q_gnt", 512'(q_gnt), 512'(1'b0));
    @(negedge clk);
    check("dc_q_gnt_next", 512'(q_gnt), 512'(1'b1));
    check("dc_no_p_done", 512'(p_done), 512'(1'b0));
    @(posedge clk); #1 q_req = 1'b0;
    wait_pulse(1'b1, 20, who, td);
    check("dc_q_done_who", 512'(who), 512'(1'b1));

    // Reset mid-pass at column 4 aborts without a done pulse
    @(posedge clk); #1 p_state = rand_state(); p_req = 1'b1;
    wait_pulse(1'b0, 20, who, tg);
    @(posedge clk); #1 p_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_at_col4", 512'(sb_din), 512'(p_state[4]));
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", 512'(busy), 512'(1'b0));
    check("abort_res_state", res_state, 512'(0));
    check("abort_sb_din", 512'(sb_din), 512'(0));
    check("abort_owner", 512'(owner), 512'(1'b1));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cnt = 0;
    repeat (NCOLS + 4) begin
      @(negedge clk);
      cnt += int'(p_done | q_done);
    end
    check("abort_no_done", 512'(cnt), 512'(0));
    @(posedge clk); #1 p_state = vecs[4].st; p_req = 1'b1;
    wait_pulse(1'b0, 20, who, tg);
    check("post_abort_gnt_p", 512'(who), 512'(1'b0));
    @(posedge clk); #1 p_req = 1'b0;
    wait_pulse(1'b1, 20, who, td);
    check("post_abort_latency", 512'(td - tg), 512'(NCOLS + 1));
    check("post_abort_res", res_state, vecs[4].exp);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 512'(sbq.size()), 512'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
